// File: rtl/vga_pattern_generator_pkg.sv
// rtl/vga_pattern_generator_pkg.sv - pattern mode encodings, 640x480 timing constants and colour helpers
package vga_pattern_generator_pkg;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_BOX      = 2'd3
  } mode_e;

  // 640x480 @ 60 Hz timing, shared with the timing controller
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int BOX_SIZE_DEFAULT = 32;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '{red: 4'h0, green: 4'h0, blue: 4'h0};
  localparam rgb_t RGB_WHITE = '{red: 4'hF, green: 4'hF, blue: 4'hF};
  localparam rgb_t RGB_BLUE  = '{red: 4'h0, green: 4'h0, blue: 4'hF};

  // Each bit of the 3-bit code switches one primary fully on (bit 2 = red)
  function automatic rgb_t rgb_from_bits(input logic [2:0] bits);
    rgb_t c;
    c.red   = {4{bits[2]}};
    c.green = {4{bits[1]}};
    c.blue  = {4{bits[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// rtl/vga_box_mover.sv - bouncing box position, stepped once per frame start
// Only instantiated when PATTERN_ANIM_EN is defined.
module vga_box_mover
  import vga_pattern_generator_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int BOX_SIZE  = BOX_SIZE_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_start,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  localparam logic [9:0] X_LIMIT = 10'(H_DISPLAY - BOX_SIZE);
  localparam logic [9:0] Y_LIMIT = 10'(V_DISPLAY - BOX_SIZE);

  logic x_neg;
  logic y_neg;

  // Reaching a limit only flips the direction; the move away happens next frame
  always_ff @(posedge clock) begin
    if (reset) begin
      box_x <= '0;
      box_y <= '0;
      x_neg <= 1'b0;
      y_neg <= 1'b0;
    end else if (frame_start) begin
      if (!x_neg) begin
        if (box_x == X_LIMIT) x_neg <= 1'b1;
        else                  box_x <= box_x + 10'd1;
      end else begin
        if (box_x == '0) x_neg <= 1'b0;
        else             box_x <= box_x - 10'd1;
      end

      if (!y_neg) begin
        if (box_y == Y_LIMIT) y_neg <= 1'b1;
        else                  box_y <= box_y + 10'd1;
      end else begin
        if (box_y == '0) y_neg <= 1'b0;
        else             box_y <= box_y - 10'd1;
      end
    end
  end

endmodule

// File: rtl/vga_pattern_generator.sv
// rtl/vga_pattern_generator.sv - two-stage VGA test pattern generator with frame-locked mode select
// Define PATTERN_ANIM_EN to build the moving-box mode; otherwise mode 3 renders black.
module vga_pattern_generator
  import vga_pattern_generator_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int BOX_SIZE  = BOX_SIZE_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       video_on,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] mode_sel,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       video_on_out,
  output logic [1:0] mode_active,
  output logic [7:0] frame_count
);

  localparam int BAR_WIDTH = H_DISPLAY / 8;

  logic  frame_start;
  mode_e pixel_mode;

  assign frame_start = (hcount == '0) && (vcount == '0);
  // The first pixel of a frame already uses the freshly requested mode
  assign pixel_mode  = frame_start ? mode_e'(mode_sel) : mode_e'(mode_active);

  logic       s1_video_on;
  logic       s1_hsync;
  logic       s1_vsync;
  logic [9:0] s1_hcount;
  logic [9:0] s1_vcount;
  mode_e      s1_mode;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_video_on <= 1'b0;
      s1_hsync    <= 1'b0;
      s1_vsync    <= 1'b0;
      s1_hcount   <= '0;
      s1_vcount   <= '0;
      s1_mode     <= MODE_BARS;
    end else begin
      s1_video_on <= video_on;
      s1_hsync    <= hsync_in;
      s1_vsync    <= vsync_in;
      s1_hcount   <= hcount;
      s1_vcount   <= vcount;
      s1_mode     <= pixel_mode;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_active <= 2'd0;
      frame_count <= 8'd0;
    end else if (frame_start) begin
      mode_active <= mode_sel;
      frame_count <= frame_count + 8'd1;
    end
  end

  logic [9:0] bar_index;
  logic       unused_bar;
  logic       box_hit;

  assign bar_index  = s1_hcount / 10'(BAR_WIDTH);
  assign unused_bar = ^bar_index[9:3];

`ifdef PATTERN_ANIM_EN
  logic [9:0]  box_x;
  logic [9:0]  box_y;
  logic [10:0] box_x_end;
  logic [10:0] box_y_end;

  vga_box_mover #(
    .H_DISPLAY (H_DISPLAY),
    .V_DISPLAY (V_DISPLAY),
    .BOX_SIZE  (BOX_SIZE)
  ) u_box (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .box_x       (box_x),
    .box_y       (box_y)
  );

  assign box_x_end = {1'b0, box_x} + 11'(BOX_SIZE);
  assign box_y_end = {1'b0, box_y} + 11'(BOX_SIZE);
  assign box_hit   = (s1_hcount >= box_x) && ({1'b0, s1_hcount} < box_x_end) &&
                     (s1_vcount >= box_y) && ({1'b0, s1_vcount} < box_y_end);
`else
  logic unused_vcount;

  assign box_hit       = 1'b0;
  assign unused_vcount = ^{box_hit, s1_vcount[9], s1_vcount[4:0]};
`endif

  rgb_t pattern;

  always_comb begin
    pattern = RGB_BLACK;
    case (s1_mode)
      MODE_BARS:     pattern = rgb_from_bits(bar_index[2:0]);
      MODE_CHECKER:  pattern = rgb_from_bits({3{s1_hcount[5] ^ s1_vcount[5]}});
      MODE_GRADIENT: pattern = '{red: s1_hcount[9:6], green: s1_vcount[8:5], blue: 4'h0};
      MODE_BOX: begin
`ifdef PATTERN_ANIM_EN
        pattern = box_hit ? RGB_WHITE : RGB_BLUE;
`else
        pattern = RGB_BLACK;
`endif
      end
      default:       pattern = RGB_BLACK;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      red          <= 4'h0;
      green        <= 4'h0;
      blue         <= 4'h0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      video_on_out <= 1'b0;
    end else begin
      {red, green, blue} <= s1_video_on ? pattern : RGB_BLACK;
      hsync_out          <= s1_hsync;
      vsync_out          <= s1_vsync;
      video_on_out       <= s1_video_on;
    end
  end

endmodule

// File: tb/tb_vga_pattern_generator.sv
// tb/tb_vga_pattern_generator.sv - directed self-checking bench for vga_pattern_generator
// Box expectations switch with PATTERN_ANIM_EN.
module tb_vga_pattern_generator;

  logic       clock = 1'b0;
  logic       reset;
  logic       video_on;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] mode_sel;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       hsync_out;
  logic       vsync_out;
  logic       video_on_out;
  logic [1:0] mode_active;
  logic [7:0] frame_count;

  int compared   = 0;
  int mismatched = 0;

`ifdef PATTERN_ANIM_EN
  localparam logic [11:0] BOX_IN  = 12'hFFF;
  localparam logic [11:0] BOX_OUT = 12'h00F;
  localparam int          N_FRAMES = 610;
`else
  localparam logic [11:0] BOX_IN  = 12'h000;
  localparam logic [11:0] BOX_OUT = 12'h000;
  localparam int          N_FRAMES = 257;
`endif

  always #5 clock = ~clock;

  vga_pattern_generator dut (
    .clock        (clock),
    .reset        (reset),
    .video_on     (video_on),
    .hcount       (hcount),
    .vcount       (vcount),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .mode_sel     (mode_sel),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .video_on_out (video_on_out),
    .mode_active  (mode_active),
    .frame_count  (frame_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic von, input logic [1:0] m);
    hcount   = h;
    vcount   = v;
    video_on = von;
    mode_sel = m;
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic von, input logic [1:0] m);
    drive(h, v, von, m);
    step();
    step();
  endtask

  logic [7:0] pat;
  logic       exp_bit;

  initial begin
    reset    = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    drive(10'd0, 10'd0, 1'b0, 2'd0);
    step();
    step();
    check("reset_rgb",   {red, green, blue}, 12'h000);
    check("reset_sync",  {hsync_out, vsync_out, video_on_out}, 3'b000);
    check("reset_mode",  mode_active, 2'd0);
    check("reset_count", frame_count, 8'd0);

    // Bars, with exact two-clock latency after a frame start
    reset = 1'b0;
    drive(10'd0, 10'd0, 1'b1, 2'd0);
    step();
    drive(10'd85, 10'd10, 1'b1, 2'd0);
    step();
    check("bars_lat1", {red, green, blue}, 12'h000);
    step();
    check("bars_85",   {red, green, blue}, 12'h00F);
    check("count_1",   frame_count, 8'd1);
    pix(10'd160, 10'd10, 1'b1, 2'd0);
    check("bars_160",  {red, green, blue}, 12'h0F0);
    pix(10'd400, 10'd10, 1'b1, 2'd0);
    check("bars_400",  {red, green, blue}, 12'hF0F);
    pix(10'd639, 10'd10, 1'b1, 2'd0);
    check("bars_639",  {red, green, blue}, 12'hFFF);

    // Checkerboard
    drive(10'd0, 10'd0, 1'b1, 2'd1);
    step();
    check("mode_chk",  mode_active, 2'd1);
    check("count_2",   frame_count, 8'd2);
    pix(10'd32, 10'd0, 1'b1, 2'd1);
    check("chk_32_0",  {red, green, blue}, 12'hFFF);
    pix(10'd32, 10'd32, 1'b1, 2'd1);
    check("chk_32_32", {red, green, blue}, 12'h000);

    // Mid-frame mode request is deferred to the next frame start
    drive(10'd0, 10'd0, 1'b1, 2'd0);
    step();
    pix(10'd300, 10'd100, 1'b1, 2'd2);
    check("midframe_rgb",  {red, green, blue}, 12'h0FF);
    check("midframe_mode", mode_active, 2'd0);
    drive(10'd0, 10'd0, 1'b1, 2'd2);
    step();
    check("grad_mode", mode_active, 2'd2);
    drive(10'd64, 10'd32, 1'b1, 2'd0);
    step();
    check("grad_0_0",  {red, green, blue}, 12'h000);
    step();
    check("grad_64_32", {red, green, blue}, 12'h110);
    pix(10'd639, 10'd479, 1'b1, 2'd0);
    check("grad_639_479", {red, green, blue}, 12'h9E0);
    check("grad_mode_held", mode_active, 2'd2);
    check("count_4",   frame_count, 8'd4);

    // Blanking and sync delay
    pix(10'd700, 10'd100, 1'b0, 2'd0);
    check("blank_rgb", {red, green, blue}, 12'h000);
    check("blank_von", video_on_out, 1'b0);
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      hsync_in = pat[i];
      vsync_in = !pat[i];
      step();
      if (i >= 1) begin
        exp_bit = pat[i-1];
        check("hsync_delay", hsync_out, exp_bit);
        exp_bit = !pat[i-1];
        check("vsync_delay", vsync_out, exp_bit);
      end
    end

    // One-clock reset mid-line
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    pix(10'd64, 10'd32, 1'b1, 2'd0);
    check("prereset_rgb", {red, green, blue}, 12'h110);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_rgb",   {red, green, blue}, 12'h000);
    check("rst_sync",  {hsync_out, vsync_out, video_on_out}, 3'b000);
    check("rst_mode",  mode_active, 2'd0);
    check("rst_count", frame_count, 8'd0);
`ifdef PATTERN_ANIM_EN
    check("rst_box", {dut.box_x, dut.box_y}, 20'd0);
`endif
    step();
    check("rst_flush", video_on_out, 1'b0);
    step();
    check("rst_track_von", video_on_out, 1'b1);
    check("rst_track_hs",  hsync_out, 1'b1);
    check("rst_track_rgb", {red, green, blue}, 12'h000);

    // Frame sweep in box mode: counter wrap and bounce
    for (int n = 1; n <= N_FRAMES; n++) begin
      drive(10'd0, 10'd0, 1'b1, 2'd3);
      step();
      if (n == 1) begin
        check("box_mode", mode_active, 2'd3);
        check("count_after_rst", frame_count, 8'd1);
`ifdef PATTERN_ANIM_EN
        check("box_pos_1", {dut.box_x, dut.box_y}, {10'd1, 10'd1});
`endif
        drive(10'd1, 10'd1, 1'b1, 2'd3);
        step();
        check("box_px_0_0", {red, green, blue}, BOX_OUT);
        step();
        check("box_px_1_1", {red, green, blue}, BOX_IN);
        pix(10'd33, 10'd1, 1'b1, 2'd3);
        check("box_px_33_1", {red, green, blue}, BOX_OUT);
        pix(10'd32, 10'd32, 1'b1, 2'd3);
        check("box_px_32_32", {red, green, blue}, BOX_IN);
      end
      if (n == 255) check("count_255", frame_count, 8'd255);
      if (n == 256) check("count_wrap", frame_count, 8'd0);
      if (n == 257) check("count_257", frame_count, 8'd1);
`ifdef PATTERN_ANIM_EN
      if (n == 608) check("box_x_608", dut.box_x, 10'd608);
      if (n == 608) check("box_y_608", dut.box_y, 10'd289);
      if (n == 609) check("box_x_hold", dut.box_x, 10'd608);
      if (n == 610) check("box_x_back", dut.box_x, 10'd607);
      if (n == 610) check("box_y_610", dut.box_y, 10'd287);
      if (n == 610) check("count_610", frame_count, 8'd98);
`endif
      drive(10'd5, 10'd5, 1'b1, 2'd3);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
